// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the blocked data cache refill controller.
package cache_pkg;
    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_BYTE = 2'b01;
    localparam logic [1:0] DT_HALF = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [7:0]       tag;
        logic [3:0][31:0] word;
    } cache_line_t;

    typedef enum logic [1:0] {IDLE, REFILL, RESP, WRITE} ctrl_state_t;

    // Type 2'b11 falls through to a full-word enable; halfwords ignore a[0].
    function automatic logic [3:0] be_from_type(input logic [1:0] dt, input logic [1:0] a);
        return dt == DT_HALF ? 4'b0011 << {a[1], 1'b0} : dt == DT_BYTE ? 4'b0001 << a : 4'hF;
    endfunction
endpackage

// File: rtl/cache_tag_array.sv
// cache_tag_array: 16-set line storage, async read port, word/byte-enabled write port.
module cache_tag_array
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rd_set,
    output cache_line_t rd_line,
    input  logic        we,
    input  logic [3:0]  wr_set,
    input  logic [3:0]  wr_word_en,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_data,
    input  logic        wr_tag_en,
    input  logic [7:0]  wr_tag,
    input  logic        wr_valid
);
    cache_line_t lines [16];

    assign rd_line = lines[rd_set];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) lines[i].valid <= 1'b0;
        end else if (we) begin
            for (int w = 0; w < 4; w++)
                for (int b = 0; b < 4; b++)
                    if (wr_word_en[w] && wr_be[b]) lines[wr_set].word[w][8*b +: 8] <= wr_data[8*b +: 8];
            if (wr_tag_en) begin
                lines[wr_set].tag   <= wr_tag;
                lines[wr_set].valid <= wr_valid;
            end
        end
    end
endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: load/store sequencer with 4-beat read-miss refill and write-through stores.
// Optional CACHE_CRITICAL_WORD_FIRST_EN: refill starts at the requested word and responds early.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 8,
    parameter int SET_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_type,
    output logic                  stall,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    ctrl_state_t           state;
    logic [ADDR_WIDTH-1:2] addr;
    logic [1:0]            beat, cnt, start;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [SET_BITS-1:0]   rd_set;
    cache_line_t           rd_line;
    logic                  hit, refill_ack, store_ack;

    // In IDLE the incoming request is probed; otherwise the latched one.
    assign cur_addr   = state == IDLE ? req_addr : {addr, 2'b00};
    assign rd_set     = cur_addr[4 +: SET_BITS];
    assign hit        = rd_line.valid && rd_line.tag == cur_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign refill_ack = state == REFILL && mem_ack;
    assign store_ack  = state == WRITE && mem_ack && hit;
    assign stall      = state == REFILL || (state == WRITE && !mem_ack) ||
                        (state == IDLE && req_valid && (req_we || !hit));
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    assign start = req_addr[3:2];
`else
    assign start = 2'b00;
`endif

    // Valid stays clear until the last beat lands, so an abandoned refill leaves the set invalid.
    cache_tag_array u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_set     (rd_set),
        .rd_line    (rd_line),
        .we         (refill_ack || store_ack),
        .wr_set     (addr[4 +: SET_BITS]),
        .wr_word_en (refill_ack ? 4'b0001 << beat : 4'b0001 << addr[3:2]),
        .wr_be      (refill_ack ? 4'hF : mem_be),
        .wr_data    (refill_ack ? mem_rdata : mem_wdata),
        .wr_tag_en  (refill_ack),
        .wr_tag     (addr[ADDR_WIDTH-1 -: TAG_WIDTH]),
        .wr_valid   (cnt == 2'd3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            beat      <= '0;
            cnt       <= '0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            rvalid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    addr <= req_addr[ADDR_WIDTH-1:2];
                    if (req_we) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_be    <= be_from_type(req_type, req_addr[1:0]);
                        mem_wdata <= req_type == DT_HALF ? {2{req_wdata[15:0]}} :
                                     req_type == DT_BYTE ? {4{req_wdata[7:0]}} : req_wdata;
                    end else if (hit) begin
                        rvalid <= 1'b1;
                        rdata  <= rd_line.word[req_addr[3:2]];
                    end else begin
                        state    <= REFILL;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_be   <= 4'hF;
                        beat     <= start;
                        cnt      <= 2'd0;
                        mem_addr <= {req_addr[ADDR_WIDTH-1:4], start, 2'b00};
                    end
                end
                REFILL: if (mem_ack) begin
                    beat     <= beat + 2'd1;
                    cnt      <= cnt + 2'd1;
                    mem_addr <= {addr[ADDR_WIDTH-1:4], beat + 2'd1, 2'b00};
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
                    if (cnt == 2'd0) begin
                        rvalid <= 1'b1;
                        rdata  <= mem_rdata;
                    end
`else
                    if (cnt == 2'd3) begin
                        rvalid <= 1'b1;
                        rdata  <= beat == addr[3:2] ? mem_rdata : rd_line.word[addr[3:2]];
                    end
`endif
                    if (cnt == 2'd3) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                    end
                end
                RESP: state <= IDLE;
                WRITE: if (mem_ack) begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: scoreboard bench with a latency-controlled RAM responder.
module tb_cache_refill_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_type = '0;
    logic        stall, rvalid, mem_req, mem_we;
    logic [31:0] rdata, mem_wdata;
    logic [15:0] mem_addr;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_type(req_type), .stall(stall), .rvalid(rvalid), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_txn [$];
    logic [31:0] exp_rd [$];
    logic [31:0] ram [16384];
    logic        mvalid [16];
    logic [7:0]  mtag [16];
    int          checks = 0, failures = 0, latency = 2, lat_cnt = 0, acks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] tb_be(input logic [1:0] dt, input logic [1:0] a);
        case (dt)
            2'b01:   return 4'b0001 << a;
            2'b10:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] tb_lanes(input logic [1:0] dt, input logic [31:0] d);
        case (dt)
            2'b01:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'b10:   return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    // RAM: holds ack off for `latency` cycles per beat, checks each beat against the scoreboard.
    initial forever begin
        txn_t t;
        @(negedge clk);
        mem_ack = 1'b0;
        if (mem_req && !rst) begin
            if (lat_cnt == latency) begin
                lat_cnt = 0;
                acks++;
                mem_ack = 1'b1;
                mem_rdata = ram[mem_addr[15:2]];
                t = exp_txn.size() != 0 ? exp_txn.pop_front() : '0;
                check("txn_addr", mem_addr, t.addr);
                check("txn_we", mem_we, t.we);
                check("txn_be", mem_be, t.be);
                if (t.we) check("txn_wdata", mem_wdata, t.wdata);
                if (mem_we)
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) ram[mem_addr[15:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end else lat_cnt++;
        end else lat_cnt = 0;
    end

    initial forever begin
        @(negedge clk);
        if (rvalid) begin
            if (exp_rd.size() != 0) check("rdata", rdata, exp_rd.pop_front());
            else check("rvalid_extra", rvalid, 1'b0);
        end
    end

    task automatic push_refill(input logic [15:0] a);
        logic [1:0] w;
        for (int k = 0; k < 4; k++) begin
            w = 2'(k);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
            w = a[3:2] + 2'(k);
`endif
            exp_txn.push_back('{we: 1'b0, addr: {a[15:4], w, 2'b00}, be: 4'hF, wdata: 32'h0});
        end
        mvalid[a[7:4]] = 1'b1;
        mtag[a[7:4]] = a[15:8];
    endtask

    task automatic access(input logic we, input logic [15:0] a, input logic [1:0] dt,
                          input logic [31:0] wd, input logic [31:0] exp_data);
        logic hit;
        int   cyc;
        hit = mvalid[a[7:4]] && mtag[a[7:4]] == a[15:8];
        if (we) exp_txn.push_back('{we: 1'b1, addr: {a[15:2], 2'b00}, be: tb_be(dt, a[1:0]), wdata: tb_lanes(dt, wd)});
        else begin
            if (!hit) push_refill(a);
            exp_rd.push_back(exp_data);
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = a; req_type = dt; req_wdata = wd;
        @(negedge clk); #1;
        check("stall_first", stall, we || !hit);
        cyc = 0;
        while (stall && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
        if (stall) check("req_timeout", stall, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("txn_drain", exp_txn.size(), 0);
        check("rd_drain", exp_rd.size(), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16384; i++) ram[i] = {i[15:0] ^ 16'h5A5A, i[15:0]};
        ram[16'h1234 >> 2] = 32'hDEADBEEF;
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {stall, rvalid, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be}, '0);
        @(posedge clk); #1 rst = 1'b0;

        access(1'b0, 16'h1234, 2'b00, 0, 32'hDEADBEEF);
        access(1'b0, 16'h1238, 2'b00, 0, ram[16'h1238 >> 2]);
        access(1'b0, 16'h5534, 2'b00, 0, ram[16'h5534 >> 2]);
        access(1'b0, 16'h1234, 2'b00, 0, 32'hDEADBEEF);
        access(1'b1, 16'h1236, 2'b01, 32'h000000AB, 0);
        access(1'b0, 16'h1234, 2'b00, 0, 32'hDEABBEEF);
        access(1'b1, 16'h2002, 2'b10, 32'h0000CAFE, 0);
        access(1'b0, 16'h2000, 2'b00, 0, {16'hCAFE, ram[16'h2000 >> 2][15:0]});
        access(1'b1, 16'h123D, 2'b10, 32'h00001357, 0);
        access(1'b1, 16'h1238, 2'b11, 32'h89ABCDEF, 0);
        access(1'b0, 16'h1238, 2'b00, 0, 32'h89ABCDEF);
        access(1'b0, 16'h123C, 2'b00, 0, ram[16'h123C >> 2]);
        latency = 0;
        access(1'b0, 16'h6638, 2'b00, 0, ram[16'h6638 >> 2]);
        access(1'b0, 16'h663C, 2'b00, 0, ram[16'h663C >> 2]);
        latency = 3;
        access(1'b0, 16'h7704, 2'b00, 0, ram[16'h7704 >> 2]);

        // Reset in the middle of a refill, with the third beat outstanding.
        push_refill(16'h4440);
        n = acks;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4440; req_type = 2'b00;
        for (int c = 0; c < 100 && acks < n + 2; c++) begin
            @(negedge clk); #1;
        end
        check("rst_beats_seen", acks - n, 2);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_stall", stall, 1'b0);
        exp_txn.delete();
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        access(1'b0, 16'h4440, 2'b00, 0, ram[16'h4440 >> 2]);
        access(1'b0, 16'h1234, 2'b00, 0, 32'hDEABBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Sequencing controller for the direct-mapped, spatially-blocked data cache.
- Geometry: 16 sets, 4 words per block, 8-bit tag, valid bit.
- Accepts one load/store at a time from the CPU memory stage and answers hits from the cache array.
- On a read miss it runs a 4-beat block refill from backing RAM over a valid/ack handshake.
- Stores are written through to RAM. Stalls the pipeline while any memory transaction is outstanding.

Parameters:
ADDR_WIDTH, 16, byte address width; A[15:8] tag, A[7:4] set, A[3:2] word, A[1:0] byte.
DATA_WIDTH, 32, word width.
TAG_WIDTH, 8, tag width.
SET_BITS, 4, log2 of set count.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  CPU request present
req_we  in  1  1 = store, 0 = load
req_addr  in  16  byte address
req_wdata  in  32  store data, LSB-aligned
req_type  in  2  00 word, 01 byte, 10 halfword
stall  out  1  CPU must hold request
rvalid  out  1  load data valid, 1-cycle pulse
rdata  out  32  full aligned word; CPU extracts byte/half
mem_req  out  1  RAM transaction valid
mem_we  out  1  RAM write
mem_addr  out  16  word-aligned RAM address
mem_wdata  out  32  RAM write data, lane-positioned
mem_be  out  4  RAM byte enables
mem_ack  in  1  RAM accepts beat; on reads, mem_rdata valid same cycle
mem_rdata  in  32  RAM read data

Behaviour:
- Clock is clk. rst is synchronous and active-high.
- Reset clears all 16 valid bits and puts the FSM in IDLE. All outputs are 0 after reset.
- Reset during REFILL or WRITE abandons the transaction, drops mem_req and leaves the set invalid.
- States: IDLE, REFILL, RESP, WRITE.
- IDLE, no request: if req_valid=0, remain in IDLE.
- IDLE, load hit (valid & tag match): rvalid=1 and rdata=block word[A[3:2]] on the next cycle; stall stays 0.
- IDLE, load miss: stall=1 in the same cycle (combinational); go to REFILL with beat counter=0.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={A[15:4],beat,2'b00}, mem_be=4'hF.
  - On each mem_ack, store mem_rdata into word slot "beat" and increment beat.
  - mem_req stays high between beats and is held until ack; RAM latency is arbitrary.
  - After beat 3 is acked: write tag, set valid, go to RESP.
- RESP: rvalid=1 with the requested word; stall=0; return to IDLE.
- IDLE, store: stall=1 in the same cycle; go to WRITE.
- WRITE:
  - mem_we=1.
  - mem_be: word=1111; half=0011<<{A[1],1'b0}; byte=0001<<A[1:0].
  - mem_wdata: data replicated into all lanes.
  - On ack return to IDLE with stall=0.
  - Store hit: the cached word is byte-merged under mem_be in the ack cycle.
  - Store miss: no allocate; the cache is unchanged.
- Halfword writes ignore A[0]. dataType=11 is treated as word.
- Back-to-back: a new request can be accepted in the cycle after RESP/WRITE completes. A load to the just-refilled block hits.
- The CPU holds req_* stable while stall=1. The controller latches the address at accept regardless.

Optional Feature:
CACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Refill begins at beat A[3:2] and wraps modulo 4 (e.g. 2,3,0,1).
  - rvalid/rdata pulse in the cycle after the critical beat is acked.
  - stall remains 1 until all 4 beats complete; rdata is not re-pulsed in RESP.
- Undefined: beats run 0..3 and the response comes only from RESP.

Decomposition:
- Package cache_pkg:
  - typedef cache_line_t, a packed struct {valid, tag[7:0], word[3:0][31:0]}.
  - enum ctrl_state_t {IDLE, REFILL, RESP, WRITE}.
  - dataType constants DT_WORD, DT_BYTE, DT_HALF.
  - function be_from_type(dt, a[1:0]).
- Sub-module cache_tag_array: 16-entry line storage with valid-clear on rst, one read port, and one write port with per-word and byte enables. The FSM stays in cache_refill_ctrl.

Test Plan:
1. Reset then load 0x1234 with RAM word(0x1234)=0xDEADBEEF, ack latency 2 -> stall high for 4 beats at mem_addr 0x1230, 0x1234, 0x1238, 0x123C; rvalid with 0xDEADBEEF; an immediate reload of 0x1238 hits with zero stall.
2. Tag conflict: after test 1, load 0x5534 (same set 3, tag 0x55) -> full refill; then reload 0x1234 -> miss again.
3. Byte store 0xAB to 0x1236 (hit) -> mem_be=0100, mem_wdata=0xABABABAB; a following load 0x1234 returns 0xDEABBEEF without a RAM access.
4. Halfword store 0xCAFE to 0x2002 (miss) -> mem_be=1100; a following load 0x2000 misses and refills.
5. Assert rst during REFILL beat 2 -> mem_req=0 next cycle; a later load of the same address performs a full 4-beat refill.
6. With CACHE_CRITICAL_WORD_FIRST_EN, load 0x1238 -> beat order 0x1238, 0x123C, 0x1230, 0x1234; rvalid after the first ack; stall clears after the fourth.
